// File: rtl/jtag_dbg_pkg.sv
// Shared constants and types for the JTAG debug command decoder.
package jtag_dbg_pkg;

  localparam int unsigned JTAG_DBG_IR_W    = 2;
  localparam int unsigned JTAG_DBG_SR_W    = 38;
  localparam int unsigned JTAG_DBG_ACT_BIT = 37;
  localparam int unsigned JTAG_DBG_DEPTH   = 4;

  // Cycles after reset release before toggle events are trusted.
  localparam logic [1:0] JTAG_DBG_PRIME_CNT = 2'd3;

  // One captured scan command: instruction plus scan register contents.
  typedef struct packed {
    logic [JTAG_DBG_IR_W-1:0] ir;
    logic [JTAG_DBG_SR_W-1:0] data;
  } jtag_dbg_cmd_t;

endpackage

// File: rtl/jtag_dbg_toggle_sync.sv
// Brings a TCK-domain toggle into clk and turns each flip into a one-cycle event.
module jtag_dbg_toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tgl,
  input  logic i_arm,
  output logic o_evt
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic r_evt;

  // Two-flop synchroniser, history flop and registered edge event (masked until armed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_sync1 <= i_tgl;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_evt   <= (r_sync2 ^ r_hist) & i_arm;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/jtag_dbg_cmd_decoder.sv
// System-clock-side JTAG debug command decoder: synchronises update-DR/IR
// toggles, queues {ir, sr} commands in a FIFO and issues one-hot action /
// no-action strobes with the popped data word on jdo.
// Optional feature: define JTAG_DBG_UIR_FLUSH_EN to let an update-IR event
// flush the queued commands.
module jtag_dbg_cmd_decoder
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned IR_W    = JTAG_DBG_IR_W,
  parameter int unsigned SR_W    = JTAG_DBG_SR_W,
  parameter int unsigned ACT_BIT = JTAG_DBG_ACT_BIT,
  parameter int unsigned DEPTH   = JTAG_DBG_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_udr_tgl,
  input  logic                       vs_uir_tgl,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  input  logic                       cmd_ready,
  input  logic                       ovf_clr,
  output logic                       cmd_valid,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [SR_W-1:0]            jdo,
  output logic [(2**IR_W)-1:0]       take_action,
  output logic [(2**IR_W)-1:0]       take_no_action,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned NI = 2**IR_W;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

`ifdef JTAG_DBG_UIR_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } cmd_t;

  logic [1:0]    r_prime;
  logic          w_armed;
  logic          w_udr_evt;
  logic          w_uir_evt;
  logic          w_flush;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_ovf_set;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  cmd_t          r_mem [DEPTH];
  cmd_t          w_new;
  cmd_t          w_head;
  logic [IR_W-1:0] w_cmd_ir_nxt;
  logic [NI-1:0] w_onehot;

  logic            r_cmd_valid;
  logic [IR_W-1:0] r_cmd_ir;
  logic [SR_W-1:0] r_jdo;
  logic [NI-1:0]   r_take_action;
  logic [NI-1:0]   r_take_no_action;
  logic            r_ovf;
  logic [PW-1:0]   r_level;

  // Post-reset priming counter; events stay masked until it saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prime <= 2'd0;
    end else if (r_prime != JTAG_DBG_PRIME_CNT) begin
      r_prime <= r_prime + 2'd1;
    end
  end

  assign w_armed = (r_prime == JTAG_DBG_PRIME_CNT);

  jtag_dbg_toggle_sync u_udr_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_tgl (vs_udr_tgl),
    .i_arm (w_armed),
    .o_evt (w_udr_evt)
  );

  jtag_dbg_toggle_sync u_uir_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_tgl (vs_uir_tgl),
    .i_arm (w_armed),
    .o_evt (w_uir_evt)
  );

  // FIFO control: push/pop/flush decisions, next pointers and next head instruction.
  always_comb begin
    w_new.ir     = ir_in;
    w_new.data   = sr;
    w_head       = r_mem[r_rptr[AW-1:0]];
    w_full       = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_flush      = w_uir_evt & FLUSH_EN;
    w_pop        = r_cmd_valid & cmd_ready;
    w_push       = w_udr_evt & ~w_flush & (~w_full | w_pop);
    w_ovf_set    = w_udr_evt & ~w_flush & w_full & ~w_pop;
    w_wptr_nxt   = w_flush ? '0 : r_wptr + PW'(w_push);
    w_rptr_nxt   = w_flush ? '0 : r_rptr + PW'(w_pop);
    w_onehot     = NI'(1) << w_head.ir;
    w_cmd_ir_nxt = '0;
    if (w_wptr_nxt != w_rptr_nxt) begin
      // A push landing in the slot that becomes the head is not in r_mem yet.
      if (w_push && (w_rptr_nxt == r_wptr)) begin
        w_cmd_ir_nxt = w_new.ir;
      end else begin
        w_cmd_ir_nxt = r_mem[w_rptr_nxt[AW-1:0]].ir;
      end
    end
  end

  // Command storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_new;
    end
  end

  // Pointers, registered head status, overflow flag and pop-side decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr           <= '0;
      r_rptr           <= '0;
      r_cmd_valid      <= 1'b0;
      r_cmd_ir         <= '0;
      r_level          <= '0;
      r_ovf            <= 1'b0;
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      r_wptr           <= w_wptr_nxt;
      r_rptr           <= w_rptr_nxt;
      r_cmd_valid      <= (w_wptr_nxt != w_rptr_nxt);
      r_cmd_ir         <= w_cmd_ir_nxt;
      r_level          <= w_wptr_nxt - w_rptr_nxt;
      r_ovf            <= w_ovf_set | (r_ovf & ~ovf_clr);
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo <= w_head.data;
        if (w_head.data[ACT_BIT]) begin
          r_take_action <= w_onehot;
        end else begin
          r_take_no_action <= w_onehot;
        end
      end
    end
  end

  assign cmd_valid      = r_cmd_valid;
  assign cmd_ir         = r_cmd_ir;
  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign ovf            = r_ovf;
  assign level          = r_level;

endmodule

// File: tb/tb_jtag_dbg_cmd_decoder.sv
// Self-checking bench for jtag_dbg_cmd_decoder (default parameters).
module tb_jtag_dbg_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr_tgl;
  logic        vs_uir_tgl;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;
  logic        ovf_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        ovf;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {ir, sr}, sticky overflow, last popped data.
  logic [39:0] q[$];
  logic        m_ovf;
  logic [37:0] m_jdo;

  jtag_dbg_cmd_decoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr_tgl     (vs_udr_tgl),
    .vs_uir_tgl     (vs_uir_tgl),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ovf            (ovf),
    .level          (level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] v;
    v = 4'b0000;
    v[i] = 1'b1;
    return v;
  endfunction

  // Flip update-DR with a new command and let it reach the FIFO (cmd_ready low).
  task automatic push_cmd(input logic [1:0] i, input logic [37:0] d);
    ir_in = i;
    sr = d;
    vs_udr_tgl = ~vs_udr_tgl;
    if (q.size() < 4) q.push_back({i, d});
    else m_ovf = 1'b1;
    tick(4);
  endtask

  // Pop one command and check head, data word, strobe and occupancy.
  task automatic pop_one();
    logic [39:0] e;
    e = q[0];
    chk("head_valid", 64'(cmd_valid), 64'd1);
    chk("head_ir", 64'(cmd_ir), 64'(e[39:38]));
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    void'(q.pop_front());
    m_jdo = e[37:0];
    chk("pop_jdo", 64'(jdo), 64'(m_jdo));
    chk("pop_act", 64'(take_action), 64'(e[37] ? onehot(e[39:38]) : 4'b0000));
    chk("pop_noact", 64'(take_no_action), 64'(e[37] ? 4'b0000 : onehot(e[39:38])));
    chk("pop_level", 64'(level), 64'(q.size()));
    tick(1);
    chk("strobe_drop", 64'({take_action, take_no_action}), 64'd0);
    chk("jdo_hold", 64'(jdo), 64'(m_jdo));
  endtask

  function automatic logic [37:0] rnd_sr();
    return 38'({$urandom(), $urandom()});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_ir"}, 64'(cmd_ir), 64'd0);
    chk({tag, "_jdo"}, 64'(jdo), 64'd0);
    chk({tag, "_strobes"}, 64'({take_action, take_no_action}), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
  endtask

  initial begin
    logic [39:0] e;
    logic [1:0]  ri;
    logic [37:0] rd;
    int          n;

    reset_n = 1'b0;
    vs_udr_tgl = 1'b0;
    vs_uir_tgl = 1'b0;
    ir_in = '0;
    sr = '0;
    cmd_ready = 1'b0;
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    m_jdo = '0;
    tick(3);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick(5);

    // Single push/pop with cmd_ready held high: strobe five edges after the flip.
    ir_in = 2'd2;
    sr = 38'h25_1234_5678;
    cmd_ready = 1'b1;
    vs_udr_tgl = ~vs_udr_tgl;
    tick(4);
    chk("t1_valid", 64'(cmd_valid), 64'd1);
    chk("t1_ir", 64'(cmd_ir), 64'd2);
    chk("t1_early", 64'({take_action, take_no_action}), 64'd0);
    tick(1);
    chk("t1_act", 64'(take_action), 64'b0100);
    chk("t1_noact", 64'(take_no_action), 64'd0);
    chk("t1_jdo", 64'(jdo), 64'h25_1234_5678);
    chk("t1_empty", 64'(cmd_valid), 64'd0);
    tick(1);
    chk("t1_drop", 64'(take_action), 64'd0);
    chk("t1_hold", 64'(jdo), 64'h25_1234_5678);
    cmd_ready = 1'b0;
    m_jdo = 38'h25_1234_5678;

    // Fill and overflow with random commands.
    for (int k = 0; k < 5; k++) push_cmd(2'($urandom_range(3)), rnd_sr());
    tick(2);
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_ovf", 64'(ovf), 64'(m_ovf));
    for (int k = 0; k < 4; k++) pop_one();
    chk("drained", 64'(cmd_valid), 64'd0);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    chk("ovf_clr", 64'(ovf), 64'd0);

    // Full FIFO with push and pop landing on the same edge.
    for (int k = 0; k < 4; k++) push_cmd(2'($urandom_range(3)), rnd_sr());
    ri = 2'($urandom_range(3));
    rd = rnd_sr();
    ir_in = ri;
    sr = rd;
    vs_udr_tgl = ~vs_udr_tgl;
    tick(3);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    e = q.pop_front();
    q.push_back({ri, rd});
    m_jdo = e[37:0];
    chk("sim_level", 64'(level), 64'd4);
    chk("sim_ovf", 64'(ovf), 64'd0);
    chk("sim_jdo", 64'(jdo), 64'(m_jdo));
    chk("sim_act", 64'(take_action), 64'(e[37] ? onehot(e[39:38]) : 4'b0000));
    chk("sim_noact", 64'(take_no_action), 64'(e[37] ? 4'b0000 : onehot(e[39:38])));
    tick(2);
    while (q.size() > 0) pop_one();

    // Random bursts, each drained in order.
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(6, 1));
      for (int k = 0; k < n; k++) push_cmd(2'($urandom_range(3)), rnd_sr());
      chk("burst_level", 64'(level), 64'((n > 4) ? 4 : n));
      chk("burst_ovf", 64'(ovf), 64'(m_ovf));
      while (q.size() > 0) pop_one();
      if (m_ovf) begin
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk("burst_clr", 64'(ovf), 64'd0);
      end
    end

    // Toggle held high across reset release must not create a command.
    reset_n = 1'b0;
    vs_udr_tgl = 1'b1;
    tick(2);
    m_jdo = '0;
    chk_all_zero("prime_rst");
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("prime_quiet", 64'(cmd_valid), 64'd0);
    end

    // Reset mid-operation while a strobe is in flight.
    push_cmd(2'($urandom_range(3)), rnd_sr());
    push_cmd(2'($urandom_range(3)), rnd_sr());
    e = q[0];
    cmd_ready = 1'b1;
    tick(1);
    chk("mid_strobe", 64'({take_action, take_no_action}),
        64'(e[37] ? {onehot(e[39:38]), 4'b0000} : {4'b0000, onehot(e[39:38])}));
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    cmd_ready = 1'b0;
    q.delete();
    m_jdo = '0;
    m_ovf = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(10);
    chk("mid_after_valid", 64'(cmd_valid), 64'd0);
    chk("mid_after_level", 64'(level), 64'd0);

    // Update-IR event with three queued commands.
    push_cmd(2'd1, rnd_sr());
    push_cmd(2'd3, rnd_sr());
    push_cmd(2'd0, rnd_sr());
    chk("pre_flush_level", 64'(level), 64'd3);
    vs_uir_tgl = ~vs_uir_tgl;
    tick(6);
`ifdef JTAG_DBG_UIR_FLUSH_EN
    q.delete();
    chk("flush_valid", 64'(cmd_valid), 64'd0);
    chk("flush_level", 64'(level), 64'd0);
`else
    chk("noflush_valid", 64'(cmd_valid), 64'd1);
    chk("noflush_level", 64'(level), 64'd3);
`endif
    chk("flush_jdo", 64'(jdo), 64'(m_jdo));
    chk("flush_ovf", 64'(ovf), 64'd0);
    while (q.size() > 0) pop_one();
    push_cmd(2'd3, {1'b0, 37'h1_2345_6789});
    pop_one();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_dbg_cmd_decoder.md
# jtag_dbg_cmd_decoder

- Parametrised system-clock-side command decoder for the on-chip JTAG debug module.
- Receives update-DR and update-IR toggle events from the TCK-domain scan logic, along with the quasi-static `ir_in`/`sr` buses, and synchronises the events.
- Buffers each captured command in a small FIFO and issues per-instruction one-hot action / no-action strobes with the matching `jdo` word to the CPU debug logic.
- Replaces the fixed 2-bit-IR, 38-bit-SR, unbuffered decoder.

## Interface
Parameters:
- IR_W, 2, instruction register width; number of instructions NI = 2**IR_W
- SR_W, 38, scan data register width
- ACT_BIT, 37, `sr` bit index that selects action (1) vs no-action (0)
- DEPTH, 4, command FIFO depth; power of 2, ≥2

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, asynchronous assert, active-low
- vs_udr_tgl  in  1  TCK-domain toggle; flips once per update-DR
- vs_uir_tgl  in  1  TCK-domain toggle; flips once per update-IR
- ir_in  in  IR_W  current instruction; stable ≥4 clk after a `vs_udr_tgl` flip
- sr  in  SR_W  scan register contents; same stability as `ir_in`
- cmd_ready  in  1  consumer accepts a command
- ovf_clr  in  1  clears `ovf`
- cmd_valid  out  1  FIFO head holds a command
- cmd_ir  out  IR_W  instruction of the FIFO head
- jdo  out  SR_W  data of the most recently popped command
- take_action  out  NI  one-hot strobe, bit = popped IR, when the popped `sr[ACT_BIT]`=1
- take_no_action  out  NI  one-hot strobe, as above, when the popped `sr[ACT_BIT]`=0
- ovf  out  1  sticky overflow flag
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- **Synchronisers:** each toggle input passes through 2 sync flops plus 1 history flop. An event is sync2≠history.
- **Post-reset priming:** a 2-bit prime counter saturates 3 cycles after `reset_n` deasserts. Events are masked until it saturates, so a toggle level that is high at reset never produces a spurious event.
- **UDR event (push):** `{ir_in, sr}` is captured into the FIFO.
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the command is dropped and `ovf` is set.
- **Pop:** occurs when `cmd_valid && cmd_ready`. In the next cycle:
  - `jdo` ← popped sr.
  - Exactly one bit of `take_action` or `take_no_action` is high for 1 cycle; the bit index is the popped IR.
  - `jdo` holds its value until the next pop.
- **Head outputs:** `cmd_ir` is valid only while `cmd_valid`=1.
- **No bypass:** a push into an empty FIFO raises `cmd_valid` the next cycle.
- **Overflow flag:** set-dominant. If `ovf_clr` and a new overflow occur in the same cycle, `ovf` stays 1.
- **Pointers:** read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full = MSBs differ and the remaining bits are equal.
  - empty = pointers equal.
- **UIR event:** ignored unless the configuration macro is defined (see Configuration).
- **Reset, all outputs:** `cmd_valid`=0, `cmd_ir`=0, `jdo`=0, `take_action`=0, `take_no_action`=0, `ovf`=0, `level`=0.
- **Reset, internal:** sync/history flops = 0, FIFO pointers = 0, prime counter = 0.
- **Reset mid-operation:** FIFO contents are discarded, and an in-flight strobe is cleared immediately.

## Timing
- **Toggle to push:** a toggle flip seen at clk edge 0 becomes an event in the cycle after edge 2. The capture occurs at edge 3.
- **`cmd_valid` rise:** `cmd_valid`=1 after edge 3, for an empty FIFO.
- **Pop handshake:** sampled at edge N. The `jdo` update and the strobe are both visible after edge N, for one cycle.
- **Worst case, UDR flip to strobe:** 5 edges, with `cmd_ready` held 1.
- **Throughput:** one push per cycle max and one pop per cycle max. Simultaneous push and pop leaves `level` unchanged.

## Configuration
- `JTAG_DBG_UIR_FLUSH_EN` defined:
  - a UIR event resets both FIFO pointers and forces `cmd_valid`=0 next cycle;
  - `jdo` and `ovf` are kept.
  - If UDR and UIR events land in the same cycle, the flush wins and the push is dropped without setting `ovf`.
- `JTAG_DBG_UIR_FLUSH_EN` undefined: the UIR synchroniser is still instantiated, but its event is unused.

## Structure
- **Package `jtag_dbg_pkg`:**
  - constants for the default IR_W, SR_W, ACT_BIT and DEPTH;
  - typedef `jtag_dbg_cmd_t` = packed struct {ir, data}, parameterised by localparam widths;
  - the prime count constant (3).
- **Sub-module `jtag_dbg_toggle_sync`:**
  - 2 sync flops, 1 history flop, priming mask input, 1-bit event output;
  - instantiated twice, once for UDR and once for UIR.
- **FIFO and decode:** inline in the top module.

## Test plan
- **Single push/pop:** after reset, flip `vs_udr_tgl` with ir_in=2, sr[37]=1, sr=0x25_1234_5678, `cmd_ready`=1 → the strobe comes 5 edges later:
  - `take_action`=4'b0100 for 1 cycle;
  - `jdo`=0x25_1234_5678;
  - `take_no_action`=0.
- **Fill and overflow:** `cmd_ready`=0, 5 UDR flips at 4-cycle spacing →
  - `level`=4 and `ovf`=1;
  - then 4 pops return the first 4 commands in order, and the 5th command is never seen;
  - `ovf_clr` → `ovf`=0.
- **Full with simultaneous events:** FIFO full, with push and pop in the same cycle → the push is accepted, `level` stays 4 and `ovf` stays 0.
- **Reset priming:** hold `vs_udr_tgl`=1 through reset deassert → `cmd_valid` stays 0 for 20 cycles.
- **Reset mid-operation:** with 2 queued and `cmd_ready`=1, assert `reset_n`=0 mid-cycle → all outputs are 0 immediately, and `cmd_valid`=0 after release.
- **Flush (macro defined):** 3 queued, then a UIR flip → after 3 edges `cmd_valid`=0 and `level`=0, with `jdo` unchanged. With the macro undefined, `level` stays 3.
